// File: rtl/ins_enc_pkg.sv
// rtl/ins_enc_pkg.sv - mnemonic set, MIPS-I opcode/funct constants, FSM states and word encoder.
// The encoder is shared by both builds; the INS_ENC_CHECK_EN build also uses mnem_defined().
package ins_enc_pkg;

  localparam logic [5:0] MNEM_COUNT = 6'd38;

  typedef enum logic [5:0] {
    M_ADD = 6'd0, M_ADDU, M_SUB, M_SUBU, M_SLT, M_SLTU, M_AND, M_OR, M_XOR, M_NOR,
    M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_JALR,
    M_BLTZ, M_BGEZ, M_J, M_JAL, M_BEQ, M_BNE, M_BLEZ, M_BGTZ,
    M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
    M_LB, M_LBU, M_LW, M_SB, M_SW
  } mnem_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A, OP_SLTIU  = 6'h0B, OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LW     = 6'h23, OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28, OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OP_SPECIAL, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm16);
    return {op, rs, rt, imm16};
  endfunction

  function automatic logic mnem_defined(input logic [5:0] mnem);
    return mnem < MNEM_COUNT;
  endfunction

  // Undefined mnemonics encode to all-zero (a MIPS NOP).
  function automatic logic [31:0] ins_encode(input logic [5:0] mnem, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [4:0] shamt, input logic [25:0] imm);
    logic [31:0] w;
    w = 32'h0;
    case (mnem)
      M_ADD:   w = r_word(rs, rt, rd, 5'd0, FN_ADD);
      M_ADDU:  w = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      M_SUB:   w = r_word(rs, rt, rd, 5'd0, FN_SUB);
      M_SUBU:  w = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      M_SLT:   w = r_word(rs, rt, rd, 5'd0, FN_SLT);
      M_SLTU:  w = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      M_AND:   w = r_word(rs, rt, rd, 5'd0, FN_AND);
      M_OR:    w = r_word(rs, rt, rd, 5'd0, FN_OR);
      M_XOR:   w = r_word(rs, rt, rd, 5'd0, FN_XOR);
      M_NOR:   w = r_word(rs, rt, rd, 5'd0, FN_NOR);
      M_SLL:   w = r_word(rs, rt, rd, shamt, FN_SLL);
      M_SRL:   w = r_word(rs, rt, rd, shamt, FN_SRL);
      M_SRA:   w = r_word(rs, rt, rd, shamt, FN_SRA);
      M_SLLV:  w = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      M_SRLV:  w = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      M_SRAV:  w = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      M_JR:    w = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      M_JALR:  w = r_word(rs, rt, rd, 5'd0, FN_JALR);
      M_BLTZ:  w = i_word(OP_REGIMM, rs, 5'd0, imm[15:0]);
      M_BGEZ:  w = i_word(OP_REGIMM, rs, 5'd1, imm[15:0]);
      M_J:     w = {OP_J, imm};
      M_JAL:   w = {OP_JAL, imm};
      M_BEQ:   w = i_word(OP_BEQ, rs, rt, imm[15:0]);
      M_BNE:   w = i_word(OP_BNE, rs, rt, imm[15:0]);
      M_BLEZ:  w = i_word(OP_BLEZ, rs, 5'd0, imm[15:0]);
      M_BGTZ:  w = i_word(OP_BGTZ, rs, 5'd0, imm[15:0]);
      M_ADDIU: w = i_word(OP_ADDIU, rs, rt, imm[15:0]);
      M_SLTI:  w = i_word(OP_SLTI, rs, rt, imm[15:0]);
      M_SLTIU: w = i_word(OP_SLTIU, rs, rt, imm[15:0]);
      M_ANDI:  w = i_word(OP_ANDI, rs, rt, imm[15:0]);
      M_ORI:   w = i_word(OP_ORI, rs, rt, imm[15:0]);
      M_XORI:  w = i_word(OP_XORI, rs, rt, imm[15:0]);
      M_LUI:   w = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
      M_LB:    w = i_word(OP_LB, rs, rt, imm[15:0]);
      M_LBU:   w = i_word(OP_LBU, rs, rt, imm[15:0]);
      M_LW:    w = i_word(OP_LW, rs, rt, imm[15:0]);
      M_SB:    w = i_word(OP_SB, rs, rt, imm[15:0]);
      M_SW:    w = i_word(OP_SW, rs, rt, imm[15:0]);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ins_enc_fifo.sv
// rtl/ins_enc_fifo.sv - small synchronous FIFO holding encoded words awaiting the output register.
module ins_enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    used;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      used <= used + CW'(1);
      else if (pop && !push) used <= used - CW'(1);
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (used == '0);
  assign full  = (used == CW'(DEPTH));

endmodule

// File: rtl/ins_encoder.sv
// rtl/ins_encoder.sv - MIPS-I instruction encoder streaming words into instruction memory.
// Optional INS_ENC_CHECK_EN: drop undefined mnemonics and raise sticky err.
module ins_encoder
  import ins_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_load,
  input  logic [9:0]  cfg_base,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_mnem,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [25:0] req_imm,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic [10:0] count,
  output logic        busy,
  output logic        err
);

  state_e      state, state_next;
  logic        accept, keep, hs, going_full, avail, load;
  logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [31:0] enc_word, fifo_head, head;

  assign accept   = req_valid & req_ready;
  assign enc_word = ins_encode(req_mnem, req_rs, req_rt, req_rd, req_shamt, req_imm);

`ifdef INS_ENC_CHECK_EN
  assign keep = accept & mnem_defined(req_mnem);

  always_ff @(posedge clk) begin
    if (rst)                                   err <= 1'b0;
    else if (accept && !mnem_defined(req_mnem)) err <= 1'b1;
  end
`else
  assign keep = accept;
  assign err  = 1'b0;
`endif

  assign hs         = imem_we & imem_ready;
  assign going_full = hs & (imem_addr == 10'd1023) & ~cfg_load;
  // An empty FIFO is bypassed so a fresh request reaches imem one cycle after acceptance.
  assign avail      = ~fifo_empty | keep;
  assign load       = (state == S_RUN) & avail & (~imem_we | hs) & ~going_full;
  assign head       = fifo_empty ? enc_word : fifo_head;
  assign fifo_pop   = load & ~fifo_empty;
  assign fifo_push  = keep & ~(load & fifo_empty);

  ins_enc_fifo #(.WIDTH(32), .DEPTH(2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (enc_word),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    case (state)
      S_IDLE: if (cfg_load) state_next = S_RUN;
      S_RUN: begin
        req_ready = ~fifo_full;
        if (going_full) state_next = S_FULL;
      end
      S_FULL: if (cfg_load) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // imem_addr doubles as the write pointer; it saturates at 1023 instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= 10'd0;
      imem_wdata <= 32'h0;
      count      <= 11'd0;
    end else begin
      if (load) begin
        imem_we    <= 1'b1;
        imem_wdata <= head;
      end else if (hs) begin
        imem_we    <= 1'b0;
      end
      if (cfg_load)                        imem_addr <= cfg_base;
      else if (hs && imem_addr != 10'd1023) imem_addr <= imem_addr + 10'd1;
      if (cfg_load) count <= 11'd0;
      else if (hs)  count <= count + 11'd1;
    end
  end

  assign busy = ~fifo_empty | imem_we;

endmodule

// File: tb/tb_ins_encoder.sv
// tb/tb_ins_encoder.sv - directed self-checking bench for ins_encoder.
module tb_ins_encoder;

  logic        clk = 1'b0;
  logic        rst, cfg_load, req_valid, req_ready, imem_we, imem_ready, busy, err;
  logic [9:0]  cfg_base, imem_addr;
  logic [5:0]  req_mnem;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [25:0] req_imm;
  logic [31:0] imem_wdata;
  logic [10:0] count;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ins_encoder dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_base(cfg_base),
    .req_valid(req_valid), .req_ready(req_ready), .req_mnem(req_mnem),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_imm(req_imm), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
    .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [9:0] base);
    cfg_base = base;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
    logic acc;
    acc = 1'b0;
    req_mnem = m; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh; req_imm = imm;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = req_ready;
      tick();
    end
    req_valid = 1'b0;
    check("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [9:0] addr, input logic [31:0] data);
    check({tag, "_we"}, {31'd0, imem_we}, 32'd1);
    check({tag, "_addr"}, {22'd0, imem_addr}, {22'd0, addr});
    check({tag, "_data"}, imem_wdata, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_base = 10'd0; req_valid = 1'b0; imem_ready = 1'b1;
    req_mnem = 6'd0; req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0; req_shamt = 5'd0; req_imm = 26'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {22'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", {21'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    tick();
    check("idle_not_ready", {31'd0, req_ready}, 32'd0);

    // Basic encode with single-cycle latency
    cfg(10'd0);
    check("run_ready", {31'd0, req_ready}, 32'd1);
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
    expect_out("addu", 10'd0, 32'h00221821);
    tick();
    check("addu_count", {21'd0, count}, 32'd1);
    check("addu_we_low", {31'd0, imem_we}, 32'd0);
    check("addu_busy_low", {31'd0, busy}, 32'd0);

    // Back-to-back mix of formats and forced fields
    send(6'd26, 5'd0, 5'd8, 5'd0, 5'd0, 26'h0001234);
    expect_out("addiu", 10'd1, 32'h24081234);
    send(6'd10, 5'd0, 5'd1, 5'd2, 5'd4, 26'd0);
    expect_out("sll", 10'd2, 32'h00011100);
    send(6'd20, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0100000);
    expect_out("j", 10'd3, 32'h08100000);
    send(6'd19, 5'd4, 5'd7, 5'd0, 5'd0, 26'h000FFFF);
    expect_out("bgez", 10'd4, 32'h0481FFFF);
    send(6'd16, 5'd31, 5'd5, 5'd6, 5'd3, 26'd0);
    expect_out("jr", 10'd5, 32'h03E00008);
    send(6'd32, 5'd3, 5'd4, 5'd0, 5'd0, 26'h000ABCD);
    expect_out("lui", 10'd6, 32'h3C04ABCD);
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd7, 26'd0);
    expect_out("add_shamt0", 10'd7, 32'h00221820);
    tick();
    check("burst_count", {21'd0, count}, 32'd8);

    // Backpressure: output register plus two FIFO entries fill up
    imem_ready = 1'b0;
    send(6'd30, 5'd1, 5'd2, 5'd0, 5'd0, 26'h00000FF);
    expect_out("stall_a", 10'd8, 32'h342200FF);
    send(6'd37, 5'd29, 5'd31, 5'd0, 5'd0, 26'h0000010);
    expect_out("stall_b_hold", 10'd8, 32'h342200FF);
    send(6'd22, 5'd1, 5'd2, 5'd0, 5'd0, 26'h000FFFE);
    check("stall_ready_low", {31'd0, req_ready}, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd1);
    tick(); tick();
    expect_out("stall_hold", 10'd8, 32'h342200FF);
    check("stall_count", {21'd0, count}, 32'd8);
    imem_ready = 1'b1;
    tick();
    expect_out("drain_sw", 10'd9, 32'hAFBF0010);
    tick();
    expect_out("drain_beq", 10'd10, 32'h1022FFFE);
    tick();
    check("drain_we_low", {31'd0, imem_we}, 32'd0);
    check("drain_count", {21'd0, count}, 32'd11);

    // Top-of-memory: two writes then FULL with the third retained
    cfg(10'd1022);
    check("base_addr", {22'd0, imem_addr}, 32'd1022);
    check("base_count", {21'd0, count}, 32'd0);
    send(6'd31, 5'd2, 5'd3, 5'd0, 5'd0, 26'h0005555);
    expect_out("xori_1022", 10'd1022, 32'h38435555);
    send(6'd12, 5'd0, 5'd6, 5'd5, 5'd31, 26'd0);
    expect_out("sra_1023", 10'd1023, 32'h00062FC3);
    send(6'd21, 5'd0, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF);
    check("full_we_low", {31'd0, imem_we}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    check("full_ready_low", {31'd0, req_ready}, 32'd0);
    check("full_count", {21'd0, count}, 32'd2);
    check("full_addr", {22'd0, imem_addr}, 32'd1023);
    tick();
    check("full_still_idle", {31'd0, imem_we}, 32'd0);
    cfg(10'd0);
    check("reload_we_low", {31'd0, imem_we}, 32'd0);
    check("reload_addr", {22'd0, imem_addr}, 32'd0);
    tick();
    expect_out("jal_retained", 10'd0, 32'h0FFFFFFF);
    tick();
    check("reload_count", {21'd0, count}, 32'd1);

    // Undefined mnemonic
    send(6'd50, 5'd1, 5'd2, 5'd3, 5'd4, 26'h3FFFFFF);
`ifdef INS_ENC_CHECK_EN
    check("undef_no_write", {31'd0, imem_we}, 32'd0);
    check("undef_err", {31'd0, err}, 32'd1);
    tick();
    check("undef_count", {21'd0, count}, 32'd1);
    check("undef_err_sticky", {31'd0, err}, 32'd1);
`else
    expect_out("undef_zero", 10'd1, 32'h00000000);
    check("undef_err0", {31'd0, err}, 32'd0);
    tick();
    check("undef_count", {21'd0, count}, 32'd2);
`endif

    // Reset in the middle of a stalled write
    imem_ready = 1'b0;
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
    check("pre_rst_we", {31'd0, imem_we}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_we", {31'd0, imem_we}, 32'd0);
    check("midrst_addr", {22'd0, imem_addr}, 32'd0);
    check("midrst_count", {21'd0, count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
